// File: rtl/ofdm_rx_sequencer.sv
// ofdm_rx_sequencer
// Receive controller for one OFDM frame. It runs fft1024 on BSRAM fft0 and
// then runs the ofdm demodulator on the FFT result. The block owns the single
// fft0 port, muxes the two masters onto it, and reports the demodulator's
// outcome to the host through a start/done handshake.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a per-wait-phase watchdog
// (TIMEOUT_CYCLES, TO_W). Without it, timeout is tied low and the wait
// states block until the expected finish arrives.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   start / busy / done              host handshake
//   success / timeout / res          frame outcome, held until next start
//   fft_start / fft_finish           fft1024 control
//   ofdm_start / ofdm_finish         ofdm control
//   ofdm_success / ofdm_res          ofdm outcome, valid with ofdm_finish
//   fft_oce/ce/wre/ad/din            fft1024 master port
//   ofdm_oce/ce/ad                   ofdm master port (read only)
//   ram_oce/ce/wre/ad/din            physical BSRAM fft0 port
//   sel                              port owner, 1 = fft1024, 0 = ofdm
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | waiting for start from the host
// FFT_GO     | fft_start pulse, port owned by fft1024
// FFT_WAIT   | waiting for fft_finish
// HANDOVER   | guard cycle, port already switched to ofdm
// OFDM_GO    | ofdm_start pulse
// OFDM_WAIT  | waiting for ofdm_finish, then report done
module ofdm_rx_sequencer #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1048575,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              timeout,
    output logic [95:0]       res,
    output logic              fft_start,
    input  logic              fft_finish,
    output logic              ofdm_start,
    input  logic              ofdm_finish,
    input  logic              ofdm_success,
    input  logic [95:0]       ofdm_res,
    input  logic              fft_oce,
    input  logic              fft_ce,
    input  logic              fft_wre,
    input  logic [ADDR_W-1:0] fft_ad,
    input  logic [DATA_W-1:0] fft_din,
    input  logic              ofdm_oce,
    input  logic              ofdm_ce,
    input  logic [ADDR_W-1:0] ofdm_ad,
    output logic              ram_oce,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    output logic              sel
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (2 ** TO_W))) begin : g_param_check
        $error("ofdm_rx_sequencer: TIMEOUT_CYCLES must be in 1 .. 2**TO_W-1");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FFT_GO    = 3'd1,
        S_FFT_WAIT  = 3'd2,
        S_HANDOVER  = 3'd3,
        S_OFDM_GO   = 3'd4,
        S_OFDM_WAIT = 3'd5
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        success_q;
    logic        fft_start_q;
    logic        ofdm_start_q;
    logic        sel_q;
    logic [95:0] res_q;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic            timeout_q;
    logic [TO_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            fft_start_q  <= 1'b0;
            ofdm_start_q <= 1'b0;
            sel_q        <= 1'b1;
            res_q        <= '0;
`ifdef SEQ_TIMEOUT_EN
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            done_q       <= 1'b0;
            fft_start_q  <= 1'b0;
            ofdm_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q high means we are in the completion cycle; a start
                    // seen here belongs to the old frame and must be re-issued.
                    if (start && !done_q) begin
                        state_q     <= S_FFT_GO;
                        busy_q      <= 1'b1;
                        success_q   <= 1'b0;
                        fft_start_q <= 1'b1;
                        sel_q       <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                S_FFT_GO: begin
                    state_q <= S_FFT_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_FFT_WAIT: begin
                    if (fft_finish) begin
                        sel_q   <= 1'b0;
                        state_q <= S_HANDOVER;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        success_q <= 1'b0;
                        timeout_q <= 1'b1;
                        sel_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_HANDOVER: begin
                    state_q      <= S_OFDM_GO;
                    ofdm_start_q <= 1'b1;
                end
                S_OFDM_GO: begin
                    state_q <= S_OFDM_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_OFDM_WAIT: begin
                    if (ofdm_finish) begin
                        success_q <= ofdm_success;
                        if (ofdm_success) begin
                            res_q <= ofdm_res;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sel_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        success_q <= 1'b0;
                        timeout_q <= 1'b1;
                        sel_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign res        = res_q;
    assign fft_start  = fft_start_q;
    assign ofdm_start = ofdm_start_q;
    assign sel        = sel_q;

`ifdef SEQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // The ofdm master is read only, so its write enable and data are forced low.
    assign ram_oce = sel_q ? fft_oce : ofdm_oce;
    assign ram_ce  = sel_q ? fft_ce  : ofdm_ce;
    assign ram_wre = sel_q ? fft_wre : 1'b0;
    assign ram_ad  = sel_q ? fft_ad  : ofdm_ad;
    assign ram_din = sel_q ? fft_din : '0;

endmodule

// File: tb/tb_ofdm_rx_sequencer.sv
module tb_ofdm_rx_sequencer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              busy, done, success, timeout;
    logic [95:0]       res;
    logic              fft_start, ofdm_start;
    logic              fft_finish = 1'b0;
    logic              ofdm_finish = 1'b0;
    logic              ofdm_success = 1'b0;
    logic [95:0]       ofdm_res = '0;
    logic              fft_oce = 1'b0, fft_ce = 1'b0, fft_wre = 1'b0;
    logic [ADDR_W-1:0] fft_ad = '0;
    logic [DATA_W-1:0] fft_din = '0;
    logic              ofdm_oce = 1'b0, ofdm_ce = 1'b0;
    logic [ADDR_W-1:0] ofdm_ad = '0;
    logic              ram_oce, ram_ce, ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;
    logic              sel;

    ofdm_rx_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(100), .TO_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .success(success), .timeout(timeout), .res(res),
        .fft_start(fft_start), .fft_finish(fft_finish),
        .ofdm_start(ofdm_start), .ofdm_finish(ofdm_finish),
        .ofdm_success(ofdm_success), .ofdm_res(ofdm_res),
        .fft_oce(fft_oce), .fft_ce(fft_ce), .fft_wre(fft_wre),
        .fft_ad(fft_ad), .fft_din(fft_din),
        .ofdm_oce(ofdm_oce), .ofdm_ce(ofdm_ce), .ofdm_ad(ofdm_ad),
        .ram_oce(ram_oce), .ram_ce(ram_ce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .sel(sel)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the host should see after each frame.
    logic [95:0] exp_res = '0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_masters(input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] oa,
                               input logic [DATA_W-1:0] fd);
        fft_ad   = fa;
        ofdm_ad  = oa;
        fft_din  = fd;
        fft_wre  = 1'b1;
        fft_ce   = 1'b1;
        fft_oce  = 1'b0;
        ofdm_ce  = 1'b0;
        ofdm_oce = 1'b1;
    endtask

    // One complete frame. spur injects starts in both wait phases, an
    // ofdm_finish during FFT_WAIT and an ofdm_finish coincident with fft_finish.
    task automatic run_frame(input int fft_lat, input int ofdm_lat, input bit succ,
                             input logic [95:0] r, input bit spur);
        int extra;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("fft_start_n1", fft_start, 1);
        chk("sel_fft", sel, 1);
        chk("done_low_go", done, 0);
        chk("success_clr", success, 0);
        chk("timeout_clr", timeout, 0);
        step();
        chk("fft_start_1cyc", fft_start, 0);
        extra = 0;
        for (int i = 0; i < fft_lat; i++) begin
            if (spur && i == 1) start = 1'b1;
            if (spur && i == 2) begin
                start        = 1'b0;
                ofdm_finish  = 1'b1;
                ofdm_success = 1'b1;
                ofdm_res     = ~r;
            end
            if (spur && i == 3) ofdm_finish = 1'b0;
            step();
            if (fft_start || done || ofdm_start || !sel) extra++;
        end
        start = 1'b0;
        ofdm_finish = 1'b0;
        chk("fft_wait_quiet", extra, 0);
        chk("arb_fft_ad", ram_ad, fft_ad);
        chk("arb_fft_wre", ram_wre, 1);
        chk("arb_fft_din", ram_din, fft_din);
        chk("arb_fft_ce", ram_ce, fft_ce);
        chk("arb_fft_oce", ram_oce, fft_oce);
        fft_finish = 1'b1;
        if (spur) begin
            ofdm_finish  = 1'b1;
            ofdm_success = 1'b1;
            ofdm_res     = ~r;
        end
        step();
        fft_finish  = 1'b0;
        ofdm_finish = 1'b0;
        chk("sel_drop", sel, 0);
        chk("no_done_handover", done, 0);
        chk("ofdm_start_m1", ofdm_start, 0);
        chk("arb_ofdm_ad", ram_ad, ofdm_ad);
        chk("arb_ofdm_wre", ram_wre, 0);
        chk("arb_ofdm_din", ram_din, 0);
        chk("arb_ofdm_ce", ram_ce, ofdm_ce);
        chk("arb_ofdm_oce", ram_oce, ofdm_oce);
        step();
        chk("ofdm_start_m2", ofdm_start, 1);
        step();
        chk("ofdm_start_1cyc", ofdm_start, 0);
        extra = 0;
        for (int i = 0; i < ofdm_lat; i++) begin
            if (spur && i == 0) start = 1'b1;
            if (spur && i == 1) start = 1'b0;
            step();
            if (fft_start || done || ofdm_start || sel || !busy) extra++;
        end
        start = 1'b0;
        chk("ofdm_wait_quiet", extra, 0);
        ofdm_finish  = 1'b1;
        ofdm_success = succ;
        ofdm_res     = r;
        step();
        ofdm_finish  = 1'b0;
        ofdm_res     = {$urandom, $urandom, $urandom};
        if (succ) exp_res = r;
        chk("done_pulse", done, 1);
        chk("busy_off", busy, 0);
        chk("success_val", success, succ);
        chk("res_val", res, exp_res);
        chk("timeout_none", timeout, 0);
        chk("sel_back", sel, 1);
        // A start during the done cycle must be ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_1cyc", done, 0);
        chk("start_at_done_busy", busy, 0);
        chk("start_at_done_fft", fft_start, 0);
        chk("success_hold", success, succ);
        chk("res_hold", res, exp_res);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_success", success, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_res", res, 0);
        chk("rst_sel", sel, 1);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_ofdm_start", ofdm_start, 0);
        rst_n = 1'b1;
        step();
        chk("idle_no_start", busy, 0);

        // Nominal frame
        set_masters(11'h3FF, 11'h155, 32'hDEAD_BEEF);
`ifdef SEQ_TIMEOUT_EN
        run_frame(80, 20, 1'b1, 96'h0B0A09080706050403020100, 1'b0);
`else
        run_frame(500, 20, 1'b1, 96'h0B0A09080706050403020100, 1'b0);
`endif
        // Failed decode keeps the previous result
        run_frame(10, 7, 1'b0, 96'hFFEEDDCCBBAA998877665544, 1'b0);
        chk("fail_keeps_res", res, 96'h0B0A09080706050403020100);

        // Spurious inputs
        run_frame(12, 9, 1'b1, 96'h123456789ABCDEF011223344, 1'b1);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            set_masters(ADDR_W'($urandom), ADDR_W'($urandom), $urandom);
            run_frame($urandom_range(4, 60), $urandom_range(2, 60), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Reset mid-frame during OFDM_WAIT
        run_frame(6, 3, 1'b1, 96'hCAFE0000BABE0000F00D0001, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
        step();
        step();
        step();
        step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_sel", sel, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_res = '0;
        chk("async_rst_sel", sel, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_success", success, 0);
        chk("async_rst_res", res, exp_res);
        chk("async_rst_done", done, 0);
        chk("async_rst_ofdm_start", ofdm_start, 0);
        chk("async_rst_wre_owner", ram_wre, fft_wre);
        step();
        rst_n = 1'b1;
        step();
        run_frame(15, 15, 1'b1, 96'h0102030405060708090A0B0C, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        // Watchdog expiry in FFT_WAIT
        begin
            int early;
            early = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            for (int i = 0; i < 99; i++) begin
                step();
                if (done) early++;
            end
            chk("wd_no_early_done", early, 0);
            step();
            chk("wd_done", done, 1);
            chk("wd_timeout", timeout, 1);
            chk("wd_success", success, 0);
            chk("wd_res_kept", res, exp_res);
            chk("wd_sel", sel, 1);
            chk("wd_busy", busy, 0);
            step();
            chk("wd_timeout_hold", timeout, 1);
            // Finish on the expiry edge wins
            start = 1'b1;
            step();
            start = 1'b0;
            chk("wd_timeout_clr", timeout, 0);
            step();
            for (int i = 0; i < 99; i++) step();
            fft_finish = 1'b1;
            step();
            fft_finish = 1'b0;
            chk("wd_race_sel", sel, 0);
            chk("wd_race_done", done, 0);
            chk("wd_race_timeout", timeout, 0);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            exp_res = '0;
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
